// File: rtl/rtc_time_editor.sv
// Display/edit controller for a six-digit hh:mm:ss clock: mirrors the RTC in SHOW,
// lets keys adjust a snapshot in EDIT, and hands the result to the RTC writer via req/ack.
module rtc_time_editor #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned TO_W           = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rtc_time,
  input  logic        rtc_valid,
  input  logic        key_mode,
  input  logic        key_sel,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic        write_ack,
  output logic [23:0] seg_bcd,
  output logic [5:0]  seg_blink,
  output logic        write_req,
  output logic [23:0] write_time,
  output logic        editing
);

  // state  | meaning
  // SHOW   | display follows rtc_time on each rtc_valid
  // EDIT   | display shows edit register, selected field blinks
  // COMMIT | write_req held until write_ack, keys ignored
  typedef enum logic [1:0] {S_SHOW, S_EDIT, S_COMMIT} state_t;
  typedef enum logic [1:0] {F_HOUR, F_MIN, F_SEC} field_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  field_t          r_field;
  logic [23:0]     r_edit;
  logic [TO_W-1:0] r_to_cnt;

  logic [7:0]  w_byte;
  logic [7:0]  w_max;
  logic [7:0]  w_adj;
  logic [23:0] w_edit_adj;
  field_t      w_field_nxt;
  logic        w_any_key;

  // Out-of-range or non-BCD fields collapse to 00 on any adjustment.
  function automatic logic [7:0] f_bcd_step(input logic [7:0] b, input logic [7:0] max,
                                            input logic up);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9 || b > max) return 8'h00;
    if (up) begin
      if (b == max)        return 8'h00;
      if (b[3:0] == 4'd9)  return {b[7:4] + 4'd1, 4'h0};
      return {b[7:4], b[3:0] + 4'd1};
    end
    if (b == 8'h00)        return max;
    if (b[3:0] == 4'd0)    return {b[7:4] - 4'd1, 4'h9};
    return {b[7:4], b[3:0] - 4'd1};
  endfunction

  function automatic logic [5:0] f_mask(input field_t f);
    case (f)
      F_HOUR:  return 6'b000011;
      F_MIN:   return 6'b001100;
      F_SEC:   return 6'b110000;
      default: return 6'b000000;
    endcase
  endfunction

  assign w_any_key = key_mode | key_sel | key_inc | key_dec;

  always_comb begin
    w_byte      = r_edit[23:16];
    w_max       = 8'h23;
    w_field_nxt = F_MIN;
    case (r_field)
      F_MIN: begin
        w_byte      = r_edit[15:8];
        w_max       = 8'h59;
        w_field_nxt = F_SEC;
      end
      F_SEC: begin
        w_byte      = r_edit[7:0];
        w_max       = 8'h59;
        w_field_nxt = F_HOUR;
      end
      default: ;
    endcase
  end

  assign w_adj = f_bcd_step(w_byte, w_max, key_inc);

  always_comb begin
    w_edit_adj = r_edit;
    case (r_field)
      F_MIN:   w_edit_adj[15:8]  = w_adj;
      F_SEC:   w_edit_adj[7:0]   = w_adj;
      default: w_edit_adj[23:16] = w_adj;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_SHOW;
      r_field    <= F_HOUR;
      r_edit     <= '0;
      r_to_cnt   <= '0;
      seg_bcd    <= '0;
      seg_blink  <= '0;
      write_req  <= 1'b0;
      write_time <= '0;
      editing    <= 1'b0;
    end else begin
      case (r_state)
        S_SHOW: begin
          seg_blink <= '0;
          if (key_mode) begin
            r_edit    <= seg_bcd;
            r_field   <= F_HOUR;
            r_to_cnt  <= '0;
            seg_blink <= f_mask(F_HOUR);
            editing   <= 1'b1;
            r_state   <= S_EDIT;
          end else if (rtc_valid) begin
            seg_bcd <= rtc_time;
          end
        end
        S_EDIT: begin
          if (w_any_key) begin
            r_to_cnt <= '0;
            if (key_mode) begin
              write_time <= r_edit;
              write_req  <= 1'b1;
              r_state    <= S_COMMIT;
            end else if (key_sel) begin
              r_field   <= w_field_nxt;
              seg_blink <= f_mask(w_field_nxt);
            end else begin
              r_edit  <= w_edit_adj;
              seg_bcd <= w_edit_adj;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt  <= '0;
            seg_blink <= '0;
            editing   <= 1'b0;
            r_state   <= S_SHOW;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          if (write_ack && write_req) begin
            write_req <= 1'b0;
            seg_bcd   <= write_time;
            seg_blink <= '0;
            editing   <= 1'b0;
            r_state   <= S_SHOW;
          end
        end
        default: r_state <= S_SHOW;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_time_editor.sv
// Checks rtc_time_editor against an arithmetic model of the display/edit/commit behaviour,
// with directed scenarios followed by randomized key, strobe, ack and reset traffic.
module tb_rtc_time_editor;
  localparam int T_OUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] rtc_time = '0;
  logic        rtc_valid = 1'b0;
  logic        key_mode = 1'b0, key_sel = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic        write_ack = 1'b0;
  logic [23:0] seg_bcd;
  logic [5:0]  seg_blink;
  logic        write_req;
  logic [23:0] write_time;
  logic        editing;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_time_editor #(.TIMEOUT_CYCLES(T_OUT), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .rtc_time(rtc_time), .rtc_valid(rtc_valid),
    .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc), .key_dec(key_dec),
    .write_ack(write_ack), .seg_bcd(seg_bcd), .seg_blink(seg_blink),
    .write_req(write_req), .write_time(write_time), .editing(editing)
  );

  always #5 clk = ~clk;

  // model: 0 = showing, 1 = editing, 2 = committing
  int          m_mode = 0;
  int          m_field = 0;
  int          m_idle = 0;
  logic [23:0] m_disp = '0, m_edit = '0, m_wtime = '0;
  logic [5:0]  m_blink = '0;
  bit          m_req = 0, m_editing = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Field value as a number; -1 when it is not a legal entry for that field.
  function automatic int field_val(input logic [7:0] b, input int maxv);
    int t, u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9 || t * 10 + u > maxv) return -1;
    return t * 10 + u;
  endfunction

  function automatic logic [7:0] adjust(input logic [7:0] b, input int maxv, input int dir);
    int v;
    v = field_val(b, maxv);
    if (v < 0) return 8'h00;
    return to_bcd((v + dir + maxv + 1) % (maxv + 1));
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [23:0] t, input bit km,
                            input bit ks, input bit ki, input bit kd, input bit ka);
    int maxv, lsb;
    if (r) begin
      m_mode = 0; m_field = 0; m_idle = 0; m_disp = '0; m_edit = '0; m_wtime = '0;
      m_blink = '0; m_req = 0; m_editing = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (km) begin
          m_edit = m_disp; m_field = 0; m_idle = 0; m_mode = 1;
          m_blink = 6'b000011; m_editing = 1;
        end else if (v) m_disp = t;
      end
      1: begin
        if (km || ks || ki || kd) begin
          m_idle = 0;
          if (km) begin
            m_wtime = m_edit; m_req = 1; m_mode = 2;
          end else if (ks) begin
            m_field = (m_field + 1) % 3;
            m_blink = 6'(3 << (2 * m_field));
          end else begin
            maxv = (m_field == 0) ? 23 : 59;
            lsb  = 16 - 8 * m_field;
            m_edit[lsb +: 8] = adjust(m_edit[lsb +: 8], maxv, ki ? 1 : -1);
            m_disp = m_edit;
          end
        end else if (m_idle == T_OUT - 1) begin
          m_idle = 0; m_mode = 0; m_blink = '0; m_editing = 0;
        end else m_idle++;
      end
      default: begin
        if (ka) begin
          m_req = 0; m_disp = m_wtime; m_mode = 0; m_blink = '0; m_editing = 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit r, input bit v, input logic [23:0] t, input bit km,
                      input bit ks, input bit ki, input bit kd, input bit ka);
    rst = r; rtc_valid = v; rtc_time = t;
    key_mode = km; key_sel = ks; key_inc = ki; key_dec = kd; write_ack = ka;
    @(posedge clk);
    #1;
    model_step(r, v, t, km, ks, ki, kd, ka);
    chk("seg_bcd", 32'(seg_bcd), 32'(m_disp));
    chk("seg_blink", 32'(seg_blink), 32'(m_blink));
    chk("write_req", 32'(write_req), 32'(m_req));
    chk("write_time", 32'(write_time), 32'(m_wtime));
    chk("editing", 32'(editing), 32'(m_editing));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 24'h0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [23:0] rt;
    step(1, 0, 24'h0, 0, 0, 0, 0, 0);
    step(1, 0, 24'h0, 0, 0, 0, 0, 0);
    step(0, 1, 24'h235958, 0, 0, 0, 0, 0);
    chk("dir_show", 32'(seg_bcd), 32'h235958);
    // edit hour, then walk minutes down a full lap
    step(0, 0, 24'h0, 1, 0, 0, 0, 0);
    step(0, 0, 24'h0, 0, 0, 1, 0, 0);
    chk("dir_hour_wrap", 32'(seg_bcd), 32'h005958);
    chk("dir_hour_mask", 32'(seg_blink), 32'h03);
    step(0, 0, 24'h0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 24'h0, 0, 0, 0, 1, 0);
    chk("dir_min_lap", 32'(seg_bcd), 32'h005958);
    step(0, 0, 24'h0, 0, 1, 0, 0, 0);
    step(0, 0, 24'h0, 0, 0, 1, 0, 0);
    step(0, 0, 24'h0, 0, 0, 1, 0, 0);
    chk("dir_sec_wrap", 32'(seg_bcd), 32'h005900);
    step(0, 0, 24'h0, 0, 0, 0, 1, 0);
    chk("dir_sec_dec", 32'(seg_bcd), 32'h005959);
    step(0, 0, 24'h0, 0, 1, 1, 0, 0);
    chk("dir_sel_prio", 32'(seg_blink), 32'h03);
    // commit with a delayed ack
    step(0, 0, 24'h0, 1, 0, 0, 0, 0);
    chk("dir_req", 32'(write_req), 32'h1);
    for (int i = 0; i < 5; i++) step(0, 1, 24'h111111, 0, 1, 1, 0, 0);
    chk("dir_hold_time", 32'(write_time), 32'h005959);
    step(0, 0, 24'h0, 0, 0, 0, 0, 1);
    chk("dir_ack_req", 32'(write_req), 32'h0);
    chk("dir_ack_disp", 32'(seg_bcd), 32'h005959);
    // abandoned edit
    step(0, 0, 24'h0, 1, 0, 0, 0, 0);
    idle(T_OUT + 2);
    chk("dir_timeout", 32'(editing), 32'h0);
    step(0, 1, 24'h123456, 0, 0, 0, 0, 0);
    // reset in the middle of a handshake
    step(0, 0, 24'h0, 1, 0, 0, 0, 0);
    step(0, 0, 24'h0, 1, 0, 0, 0, 0);
    step(1, 0, 24'h0, 0, 0, 0, 0, 0);
    chk("dir_rst_req", 32'(write_req), 32'h0);
    step(0, 0, 24'h0, 0, 0, 0, 0, 1);
    step(0, 0, 24'h0, 0, 0, 0, 0, 1);
    // random traffic, including illegal BCD snapshots
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1) == 0)
        rt = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
              to_bcd($urandom_range(0, 59))};
      else
        rt = 24'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, rt,
           $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 3) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rtc_time_editor.md
Name: rtc_time_editor

Overview:
Produces the BCD display word and per-digit blink mask that the six-digit seven-segment display driver consumes, and lets the user set hh:mm:ss from pre-debounced key pulses. In SHOW it mirrors the live time from the RTC reader. In EDIT it blinks the selected field and adjusts it. On confirm it issues a write request with a req/ack handshake toward the RTC writer.

Parameters:
TIMEOUT_CYCLES, 500000000, idle cycles in EDIT before abandoning the edit (10 s at 50 MHz); must be ≥2.
TO_W, 29, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rtc_time  input  24  live BCD time {h10,h1,m10,m1,s10,s1}, 4 bits each, MSB first
rtc_valid  input  1  one-cycle strobe: rtc_time is fresh
key_mode  input  1  one-cycle pulse: enter EDIT, or confirm edit
key_sel  input  1  one-cycle pulse: select next field
key_inc  input  1  one-cycle pulse: increment selected field
key_dec  input  1  one-cycle pulse: decrement selected field
write_ack  input  1  RTC writer accepted write_time
seg_bcd  output  24  BCD word to display driver, same packing as rtc_time
seg_blink  output  6  blink mask; bit0 = digit of seg_bcd[23:20] … bit5 = digit of seg_bcd[3:0]
write_req  output  1  request to write write_time into RTC
write_time  output  24  BCD time to write, stable while write_req=1
editing  output  1  high in EDIT and COMMIT

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst); all outputs are registered.
- Reset values: state=SHOW, field=HOUR, seg_bcd=0, seg_blink=0, write_req=0, write_time=0, editing=0, timeout counter=0.
- Fields and blink masks: HOUR (seg_bcd[23:16], range 00–23, mask 6'b000011), MIN ([15:8], 00–59, mask 6'b001100), SEC ([7:0], 00–59, mask 6'b110000).
- Key priority when several pulses arrive in the same cycle: mode > sel > inc > dec. Only the highest-priority key acts.
- SHOW:
  - On rtc_valid, seg_bcd <= rtc_time on the next edge. seg_blink=0.
  - On key_mode: snapshot the current seg_bcd into the edit register, field<=HOUR, go to EDIT. rtc_time is ignored from this point on.
- EDIT:
  - seg_bcd = edit register. seg_blink = mask of the selected field. editing=1.
  - key_sel rotates HOUR→MIN→SEC→HOUR.
  - key_inc: field+1 in BCD with wrap. Hours 23→00, min/sec 59→00, x9→(x+1)0.
  - key_dec: field−1 with wrap. 00→23 for hours, 00→59 for min/sec, x0→(x−1)9.
  - A field holding a non-BCD or out-of-range value becomes 00 on any inc or dec.
  - Result is visible on seg_bcd one cycle after the key pulse.
  - Any key pulse clears the timeout counter; otherwise it counts up each cycle. On reaching TIMEOUT_CYCLES−1: go to SHOW with no write, and seg_blink=0 on the next cycle.
  - key_mode: write_time <= edit register, write_req <= 1, go to COMMIT.
- COMMIT:
  - write_req and write_time are held until write_ack is sampled high while write_req=1.
  - On that edge: write_req <= 0, seg_bcd <= write_time, go to SHOW.
  - All keys and rtc_valid are ignored.
  - write_ack outside COMMIT is ignored. No timeout applies in COMMIT.
- Reset asserted in any state, including mid-handshake, returns everything to reset values on the next edge; a pending write_req drops immediately.
- The first rtc_valid after returning to SHOW overwrites seg_bcd normally.

Test Plan:
- Reset then rtc_valid with rtc_time=24'h235958 → seg_bcd=24'h235958 one cycle later, seg_blink=0, editing=0.
- From 23:59:58, pulse key_mode then key_inc → seg_bcd=24'h005958, seg_blink=6'b000011. Then key_sel, key_dec ×60 → minutes back to 59, no borrow into hours.
- In EDIT on SEC=58: key_inc ×2 → 00; key_dec → 59. Simultaneous key_sel+key_inc → field changes to next, value unchanged.
- Confirm with key_mode → write_req=1, write_time=edited value. Hold write_ack=0 for 5 cycles → req/time stable. Ack → req=0 next cycle, state SHOW, seg_bcd=write_time.
- With TIMEOUT_CYCLES=16: enter EDIT, no keys for 16 cycles → back to SHOW, write_req never asserted, seg_blink=0.
- Assert rst during COMMIT with write_req=1 → write_req=0 and all outputs at reset values the next cycle; a later write_ack has no effect.
